ibuf2ddr: RTL

- Read-back path for the PE index buffers: write-back counterpart to the DDR-to-ibuf loader.
- On a configuration handshake, reads N index pairs from one selected PE's index buffer starting at address 0.
- Packs the pairs IDX_BATCH per DDR word and emits them on a valid/ready DDR write stream.
- Sits between the PE array index buffers and the DDR write-stream arbiter; used for buffer dump and debug read-back.

---
 rtl/ibuf2ddr_pkg.sv | 29 ++
 rtl/ibuf2ddr_if.sv | 35 +++
 rtl/ibuf2ddr_idx_packer.sv | 91 +++++++++
 rtl/ibuf2ddr.sv | 111 +++++++++++
 4 files changed

// File: rtl/ibuf2ddr_pkg.sv
// Shared widths for the index-buffer <-> DDR paths, plus the pair-per-word batch size.
// Loader and read-back both import IDX_BATCH from here so their packing always agrees.
package ibuf2ddr_pkg;

    localparam int DDR_W = 64;
    localparam int IDX_W = 8;

    function automatic int bw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int PAIR_W    = 2 * IDX_W;
    localparam int IDX_BATCH = DDR_W / IDX_W / 2;

    localparam logic [1:0] MODE_SWAP = 2'b01;

    typedef logic [PAIR_W-1:0] pair_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    function automatic pair_t swap_halves(input pair_t p);
        return {p[IDX_W-1:0], p[PAIR_W-1:IDX_W]};
    endfunction

endpackage

// File: rtl/ibuf2ddr_if.sv
// Config, index-buffer read and DDR write-stream signals of the ibuf2ddr read-back path.
// slave is the ibuf2ddr side; master is the PE array / DDR arbiter / controller side.
interface ibuf2ddr_if
    import ibuf2ddr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PE_NUM = 32,
    parameter int PE_W   = 5
);
    logic                       conf_valid;
    logic                       conf_ready;
    logic [3:0]                 conf_mode;
    logic [7:0]                 conf_idx_num;
    logic [PE_W-1:0]            conf_pe;

    logic                       idx_rd_en;
    logic [ADDR_W-1:0]          idx_rd_addr;
    logic [PE_NUM*PAIR_W-1:0]   idx_rd_data;

    logic [DDR_W-1:0]           ddr_data;
    logic                       ddr_valid;
    logic                       ddr_ready;
    logic                       ddr_last;

    modport slave (
        input  conf_valid, conf_mode, conf_idx_num, conf_pe, idx_rd_data, ddr_ready,
        output conf_ready, idx_rd_en, idx_rd_addr, ddr_data, ddr_valid, ddr_last
    );

    modport master (
        output conf_valid, conf_mode, conf_idx_num, conf_pe, idx_rd_data, ddr_ready,
        input  conf_ready, idx_rd_en, idx_rd_addr, ddr_data, ddr_valid, ddr_last
    );

endinterface

// File: rtl/ibuf2ddr_idx_packer.sv
// Packs returning index pairs into DDR words (optional half-swap, zero fill) behind an output register.
// Word registers the cycle its last lane lands; a full word stalls new reads until the output frees.
module idx_packer
    import ibuf2ddr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  logic             swap_i,
    input  logic             rvld_i,
    input  logic             rlast_i,
    input  pair_t            rdat_i,
    input  logic             ddr_rdy_i,
    output logic             can_issue_o,
    output logic [DDR_W-1:0] ddr_dat_o,
    output logic             ddr_vld_o,
    output logic             ddr_last_o
);
    localparam int LANE_W = bw(IDX_BATCH);
    localparam int CNT_W  = bw(IDX_BATCH + 1);

    pair_t [IDX_BATCH-1:0] lanes_q, lanes_d;
    logic [LANE_W-1:0]     wr_lane_q;
    logic [CNT_W-1:0]      lane_cnt_q, lane_cnt_d;
    logic                  pend_q, pend_last_q;
    logic [DDR_W-1:0]      out_dat_q;
    logic                  out_vld_q, out_last_q;

    pair_t pair_in;
    logic  word_done, out_free, move;

    assign pair_in     = swap_i ? swap_halves(rdat_i) : rdat_i;
    assign word_done   = rvld_i && ((wr_lane_q == LANE_W'(IDX_BATCH - 1)) || rlast_i);
    assign out_free    = !out_vld_q || ddr_rdy_i;
    assign move        = (word_done || pend_q) && out_free;
    assign can_issue_o = lane_cnt_q < CNT_W'(IDX_BATCH);

    always_comb begin
        lanes_d = lanes_q;
        if (rvld_i) begin
            lanes_d[wr_lane_q] = pair_in;
        end
        lane_cnt_d = move ? '0 : lane_cnt_q;
        if (issue_i) begin
            lane_cnt_d = lane_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q     <= '0;
            wr_lane_q   <= '0;
            lane_cnt_q  <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            out_dat_q   <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            if (move) begin
                // Lanes are cleared on hand-off so a short final word is zero filled.
                out_dat_q   <= DDR_W'(lanes_d);
                out_vld_q   <= 1'b1;
                out_last_q  <= pend_q ? pend_last_q : rlast_i;
                lanes_q     <= '0;
                wr_lane_q   <= '0;
                pend_q      <= 1'b0;
                pend_last_q <= 1'b0;
            end else begin
                lanes_q <= lanes_d;
                if (word_done) begin
                    pend_q      <= 1'b1;
                    pend_last_q <= rlast_i;
                    wr_lane_q   <= '0;
                end else if (rvld_i) begin
                    wr_lane_q <= wr_lane_q + 1'b1;
                end
                if (out_vld_q && ddr_rdy_i) begin
                    out_vld_q  <= 1'b0;
                    out_last_q <= 1'b0;
                end
            end
        end
    end

    assign ddr_dat_o  = out_dat_q;
    assign ddr_vld_o  = out_vld_q;
    assign ddr_last_o = out_last_q;

endmodule

// File: rtl/ibuf2ddr.sv
// Reads N index pairs from one PE buffer (addr 0..N-1) and streams them packed to DDR.
// Read data lands 1 cycle after the strobe; reads throttle on lane credit when ddr_ready stalls.
module ibuf2ddr
    import ibuf2ddr_pkg::*;
#(
    parameter int IDX_DEPTH = 256,
    parameter int ADDR_W    = bw(IDX_DEPTH),
    parameter int PE_NUM    = 32,
    parameter int PE_W      = bw(PE_NUM)
) (
    input  logic      clk,
    input  logic      rst,
    ibuf2ddr_if.slave bus
);
    state_t            state_q;
    logic              conf_ready_q;
    logic              swap_q;
    logic              zero_q;
    logic [7:0]        n_q;
    logic [7:0]        rd_cnt_q;
    logic [PE_W-1:0]   pe_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rvld_q;
    logic              rlast_q;

    logic              can_issue, issue, last_issue, conf_hs, last_hs;
    pair_t             pe_pair;
    logic [DDR_W-1:0]  pk_dat;
    logic              pk_vld, pk_last;
    logic              unused_mode;

    assign conf_hs     = bus.conf_valid && conf_ready_q;
    assign issue       = (state_q == ST_READ) && can_issue;
    assign last_issue  = issue && (rd_cnt_q == n_q - 8'd1);
    assign last_hs     = pk_vld && bus.ddr_ready && pk_last;
    assign pe_pair     = bus.idx_rd_data[pe_q*PAIR_W +: PAIR_W];
    assign unused_mode = ^{bus.conf_mode[3], bus.conf_mode[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            conf_ready_q <= 1'b1;
            swap_q       <= 1'b0;
            zero_q       <= 1'b0;
            n_q          <= '0;
            rd_cnt_q     <= '0;
            pe_q         <= '0;
            addr_q       <= '0;
            rvld_q       <= 1'b0;
            rlast_q      <= 1'b0;
        end else begin
            rvld_q  <= issue;
            rlast_q <= last_issue;
            case (state_q)
                ST_IDLE: begin
                    if (conf_hs) begin
                        n_q          <= bus.conf_idx_num;
                        pe_q         <= bus.conf_pe;
                        swap_q       <= (bus.conf_mode[2:1] == MODE_SWAP);
                        zero_q       <= (bus.conf_idx_num == 8'd0);
                        rd_cnt_q     <= '0;
                        addr_q       <= '0;
                        conf_ready_q <= 1'b0;
                        // An empty request spends a single cycle in DRAIN and emits nothing.
                        state_q      <= (bus.conf_idx_num == 8'd0) ? ST_DRAIN : ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + 8'd1;
                        addr_q   <= (addr_q == ADDR_W'(IDX_DEPTH - 1)) ? '0 : addr_q + 1'b1;
                        if (last_issue) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (zero_q || last_hs) begin
                        state_q      <= ST_IDLE;
                        conf_ready_q <= 1'b1;
                        zero_q       <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    idx_packer u_pack (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue),
        .swap_i      (swap_q),
        .rvld_i      (rvld_q),
        .rlast_i     (rlast_q),
        .rdat_i      (pe_pair),
        .ddr_rdy_i   (bus.ddr_ready),
        .can_issue_o (can_issue),
        .ddr_dat_o   (pk_dat),
        .ddr_vld_o   (pk_vld),
        .ddr_last_o  (pk_last)
    );

    assign bus.conf_ready  = conf_ready_q;
    assign bus.idx_rd_en   = issue;
    assign bus.idx_rd_addr = addr_q;
    assign bus.ddr_data    = pk_dat;
    assign bus.ddr_valid   = pk_vld;
    assign bus.ddr_last    = pk_last;

endmodule
